crc_encoder_stream: RTL and testbench

Streaming CRC generator, the transmit-side partner of the team's CRC checker. It accepts a framed word stream over a valid/ready handshake and passes each word through unchanged. It accumulates a running CRC over the frame and, after the last data word, appends one CRC word to the output stream. It sits between the packet source and the link serializer, so the far-end checker can validate each frame.

---
 rtl/crc_pkg.sv | 13 +
 rtl/crc_word_update.sv | 22 ++
 rtl/crc_encoder_stream.sv | 114 +++++++++++
 tb/tb_crc_encoder_stream.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC constants and sequencing state for the stream encoder and checker.
package crc_pkg;

   localparam int         CRC_W    = 8;
   localparam logic [7:0] CRC_POLY = 8'h2F;
   localparam logic [7:0] CRC_INIT = 8'h00;

   typedef enum logic {
      PASS   = 1'b0,
      APPEND = 1'b1
   } crc_state_e;

endpackage

// File: rtl/crc_word_update.sv
// One-word CRC step: f(crc ^ data), MSB-first, non-reflected, no final XOR.
module crc_word_update #(
   parameter int             N    = 8,
   parameter logic [N-1:0]   POLY = 8'h2F
) (
   input  logic [N-1:0] crc_i,
   input  logic [N-1:0] data_i,
   output logic [N-1:0] crc_o
);

   // Bit-serial polynomial division unrolled over the word width.
   always_comb begin
      logic [N-1:0] x;
      x = crc_i ^ data_i;
      for (int i = 0; i < N; i++) begin
         if (x[N-1]) x = (x << 1) ^ POLY;
         else        x = x << 1;
      end
      crc_o = x;
   end

endmodule

// File: rtl/crc_encoder_stream.sv
// Streaming CRC generator: forwards framed words and appends one CRC word per frame.
//
// state  | meaning
// PASS   | forwarding data words, CRC accumulates on each accept
// APPEND | last data word taken; waiting for a free output slot to emit the CRC
module crc_encoder_stream
   import crc_pkg::*;
#(
   parameter int           N    = CRC_W,
   parameter logic [N-1:0] POLY = CRC_POLY,
   parameter logic [N-1:0] INIT = CRC_INIT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [N-1:0] s_data,
   input  logic         s_last,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [N-1:0] m_data,
   output logic         m_last,
   output logic [N-1:0] crc_value,
   output logic         frame_done
);

   crc_state_e   state_q, state_d;
   logic [N-1:0] crc_q, crc_d;
   logic         m_valid_q, m_valid_d;
   logic [N-1:0] m_data_q, m_data_d;
   logic         m_last_q, m_last_d;
   logic [N-1:0] crc_value_q, crc_value_d;
   logic         frame_done_q, frame_done_d;
   logic [N-1:0] crc_upd;
   logic         out_free;

   crc_word_update #(
      .N    (N),
      .POLY (POLY)
   ) u_crc_word_update (
      .crc_i  (crc_q),
      .data_i (s_data),
      .crc_o  (crc_upd)
   );

   // Single output slot is reusable when empty or being drained this cycle.
   assign out_free = !m_valid_q || m_ready;

   // Next-state, output-slot loading and upstream ready.
   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_last_d     = m_last_q;
      crc_value_d  = crc_value_q;
      s_ready      = 1'b0;
      frame_done_d = m_valid_q && m_ready && m_last_q;

      case (state_q)
         PASS: begin
            s_ready = out_free;
            if (s_valid && out_free) begin
               m_data_d  = s_data;
               m_last_d  = 1'b0;
               m_valid_d = 1'b1;
               crc_d     = crc_upd;
               if (s_last) state_d = APPEND;
            end else if (m_ready) begin
               m_valid_d = 1'b0;
            end
         end
         APPEND: begin
            if (out_free) begin
               m_data_d    = crc_q;
               m_last_d    = 1'b1;
               m_valid_d   = 1'b1;
               crc_d       = INIT;
               crc_value_d = crc_q;
               state_d     = PASS;
            end
         end
         default: state_d = PASS;
      endcase
   end

   // State and datapath registers; reset drops any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= PASS;
         crc_q        <= INIT;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
         crc_value_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
         crc_value_q  <= crc_value_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_last     = m_last_q;
   assign crc_value  = crc_value_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_crc_encoder_stream.sv
// Scoreboard bench for crc_encoder_stream.
module tb_crc_encoder_stream;

   localparam int         N    = 8;
   localparam logic [7:0] POLY = 8'h2F;
   localparam logic [7:0] INIT = 8'h00;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } word_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data = '0;
   logic       s_last = 1'b0;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_last;
   logic [7:0] crc_value;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   word_t      in_q[$];
   logic [8:0] exp_q[$];
   int         acc_cyc[$];
   logic [7:0] mdl_crc = INIT;
   bit         acc_pend = 0;
   int         vld_pct = 100;
   int         rdy_pct = 100;
   int         rdy_hold = 0;
   int         cyc = 0;
   int         fd_cnt = 0;
   int         frames_sent = 0;
   bit         hold_prev = 0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   crc_encoder_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .crc_value  (crc_value),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] x;
      x = crc ^ data;
      for (int i = 0; i < N; i++) begin
         if (x[7]) x = {x[6:0], 1'b0} ^ POLY;
         else      x = {x[6:0], 1'b0};
      end
      return x;
   endfunction

   // Monitor: all sampling on the falling edge, away from the active edge.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            hold_prev = 0;
         end else begin
            if (frame_done) fd_cnt++;
            if (hold_prev) begin
               check_val("hold_valid", m_valid, 1);
               check_val("hold_data", m_data, prev_data);
               check_val("hold_last", m_last, prev_last);
            end
            if (m_valid && !m_ready) check_val("s_ready_full", s_ready, 0);
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check_val("spurious_word", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  check_val("m_data", m_data, e[7:0]);
                  check_val("m_last", m_last, e[8]);
               end
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (s_valid && s_ready) begin
               acc_pend = 1;
               acc_cyc.push_back(cyc);
               mdl_crc = crc_ref(mdl_crc, s_data);
               exp_q.push_back({1'b0, s_data});
               if (s_last) begin
                  exp_q.push_back({1'b1, mdl_crc});
                  mdl_crc = INIT;
                  frames_sent++;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (acc_pend) begin
         void'(in_q.pop_front());
         acc_pend = 0;
      end
      if (in_q.size() > 0 && $urandom_range(99) < vld_pct) begin
         s_valid = 1'b1;
         s_data  = in_q[0].d;
         s_last  = in_q[0].l;
      end else begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         s_last  = 1'($urandom);
      end
      if (rdy_hold > 0) begin
         m_ready = 1'b0;
         rdy_hold--;
      end else begin
         m_ready = ($urandom_range(99) < rdy_pct);
      end
   endtask

   task automatic add_frame(input logic [7:0] d0, input int len);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w.d = (i == 0) ? d0 : 8'h00;
         w.l = (i == len - 1);
         in_q.push_back(w);
      end
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0 || acc_pend) && n < limit) begin
         step();
         n++;
      end
      if (n >= limit) check_val("drain_timeout", n, 0);
      for (int i = 0; i < 3; i++) step();
   endtask

   initial begin
      int fd0, fs0, n, len;
      word_t w;

      #1 rst_n = 1'b0;
      #11;
      check_val("rst_m_valid", m_valid, 0);
      check_val("rst_m_data", m_data, 0);
      check_val("rst_m_last", m_last, 0);
      check_val("rst_crc_value", crc_value, 0);
      check_val("rst_frame_done", frame_done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // One-word frame 0x01
      fd0 = fd_cnt;
      add_frame(8'h01, 1);
      drain(200);
      check_val("crc_1w_01", crc_value, 8'h2F);
      check_val("fd_1w", fd_cnt - fd0, 1);

      // Frame {0x01, 0x00}, consecutive accepts at full rate
      acc_cyc.delete();
      add_frame(8'h01, 2);
      drain(200);
      check_val("crc_2w", crc_value, 8'hE9);
      check_val("acc_2w_cnt", acc_cyc.size(), 2);
      if (acc_cyc.size() == 2) check_val("acc_2w_gap", acc_cyc[1] - acc_cyc[0], 1);

      // One-word frame 0x00
      add_frame(8'h00, 1);
      drain(200);
      check_val("crc_1w_00", crc_value, 8'h00);

      // Backpressure mid-frame
      add_frame(8'h01, 2);
      step();
      step();
      rdy_hold = 5;
      drain(200);
      check_val("crc_bp", crc_value, 8'hE9);

      // Back-to-back one-word frames: one input bubble each
      acc_cyc.delete();
      fd0 = fd_cnt;
      add_frame(8'h01, 1);
      add_frame(8'h01, 1);
      drain(200);
      check_val("b2b_acc_cnt", acc_cyc.size(), 2);
      if (acc_cyc.size() == 2) check_val("b2b_gap", acc_cyc[1] - acc_cyc[0], 2);
      check_val("b2b_crc", crc_value, 8'h2F);
      check_val("b2b_fd", fd_cnt - fd0, 2);

      // Reset after the first word of a frame
      acc_cyc.delete();
      add_frame(8'h01, 2);
      n = 0;
      while (acc_cyc.size() == 0 && n < 50) begin
         step();
         n++;
      end
      check_val("rst_mid_acc", acc_cyc.size(), 1);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_valid", m_valid, 0);
      check_val("rst_mid_crcval", crc_value, 0);
      in_q.delete();
      exp_q.delete();
      acc_pend = 0;
      mdl_crc  = INIT;
      s_valid  = 1'b0;
      m_ready  = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      add_frame(8'h01, 1);
      drain(200);
      check_val("rst_mid_crc", crc_value, 8'h2F);

      // Random frames with random gaps on both sides
      vld_pct = 60;
      rdy_pct = 60;
      fd0 = fd_cnt;
      fs0 = frames_sent;
      for (int f = 0; f < 100; f++) begin
         len = $urandom_range(6, 1);
         for (int i = 0; i < len; i++) begin
            w.d = 8'($urandom);
            w.l = (i == len - 1);
            in_q.push_back(w);
         end
      end
      drain(20000);
      check_val("rnd_frames_sent", frames_sent - fs0, 100);
      check_val("rnd_frame_done", fd_cnt - fd0, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
